// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module : uart_tx_pkg
// Brief  : Shared state encodings and line constants for the UART blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_baud_edge_det.sv
// ============================================================================
// Module : baud_edge_det
// Brief  : Turns the clk-domain baud square wave into a one-cycle rising tick.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic baud_clk,
  output logic tick
);

  logic r_baud_q;

  // Resetting to 1 suppresses a false tick when reset releases with baud_clk high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud_q <= 1'b1;
    end else begin
      r_baud_q <= baud_clk;
    end
  end

  assign tick = baud_clk & ~r_baud_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : UART transmitter, valid/ready byte in, start/data/parity/stop out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(DATA_BITS - 1);
  localparam logic             c_last_stop = 1'(STOP_BITS - 1);
  localparam logic             c_par_odd   = (PARITY_ODD != 0);

  tx_state_e            r_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_par;
  logic                 w_tick;

  baud_edge_det u_baud_edge_det (
    .clk      (clk),
    .reset    (reset),
    .baud_clk (baud_clk),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      tx         <= UART_IDLE_LVL;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
    end else begin
      case (r_state)
        // Accept ignores any tick in the same cycle; the start bit waits for the next one.
        IDLE: begin
          if (tx_valid && tx_ready) begin
            r_shreg  <= tx_data;
            r_par    <= (^tx_data) ^ c_par_odd;
            r_state  <= WAIT;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (w_tick) begin
            r_state <= START;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state   <= DATA;
            tx        <= r_shreg[0];
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= '0;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == c_last_bit) begin
              r_stop_cnt <= 1'b0;
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                tx      <= r_par;
              end else begin
                r_state <= STOP;
                tx      <= UART_IDLE_LVL;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              tx        <= r_shreg[0];
              r_shreg   <= r_shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_state    <= STOP;
            tx         <= UART_IDLE_LVL;
            r_stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == c_last_stop) begin
              r_state  <= IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          tx       <= UART_IDLE_LVL;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module : tb_uart_tx
// Brief  : Directed bench for uart_tx in 8N1, 8E1, 8O1 and 8N2 configurations.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_clk = 1'b0;
  logic       baud_run = 1'b1;
  logic [1:0] baud_cnt = 2'd0;

  logic [3:0] tx_valid_v = 4'b0;
  logic [7:0] tx_data_v [4];
  wire  [3:0] tx_v;
  wire  [3:0] ready_v;
  wire  [3:0] busy_v;

  int n_checks = 0;
  int n_fail   = 0;
  int gap;

  always #5 clk = ~clk;

  // Bit period of 8 clk; baud_run freezes the wave at its current level.
  always @(posedge clk) begin
    if (baud_run) begin
      if (baud_cnt == 2'd3) begin
        baud_cnt <= 2'd0;
        baud_clk <= ~baud_clk;
      end else begin
        baud_cnt <= baud_cnt + 2'd1;
      end
    end
  end

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data_v[0]),
    .tx_valid(tx_valid_v[0]), .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data_v[1]),
    .tx_valid(tx_valid_v[1]), .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut_8o1 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data_v[2]),
    .tx_valid(tx_valid_v[2]), .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]));

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_8n2 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data_v[3]),
    .tx_valid(tx_valid_v[3]), .tx_ready(ready_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d);
    @(negedge clk);
    tx_data_v[idx]  = d;
    tx_valid_v[idx] = 1'b1;
    @(negedge clk);
    check_eq($sformatf("accept%0d_ready", idx), 32'(ready_v[idx]), 32'd0);
    check_eq($sformatf("accept%0d_busy", idx), 32'(busy_v[idx]), 32'd1);
  endtask

  // exp[i] is the i-th bit on the line, starting with the start bit.
  task automatic frame_check(input int idx, input string tag, input logic [11:0] exp,
                             input int len, input logic [7:0] nxt_data,
                             input logic nxt_valid, output int gap_out);
    int n = 0;
    while (tx_v[idx] !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    gap_out = n;
    check_eq({tag, "_start"}, 32'(tx_v[idx]), 32'd0);
    tx_data_v[idx]  = nxt_data;
    tx_valid_v[idx] = nxt_valid;
    for (int i = 0; i < len; i++) begin
      repeat ((i == 0) ? 4 : 8) @(negedge clk);
      check_eq($sformatf("%s_bit%0d", tag, i), 32'(tx_v[idx]), 32'(exp[i]));
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_ready_before_end"}, 32'(ready_v[idx]), 32'd0);
    @(negedge clk);
    check_eq({tag, "_ready_at_end"}, 32'(ready_v[idx]), 32'd1);
    check_eq({tag, "_busy_at_end"}, 32'(busy_v[idx]), 32'd0);
  endtask

  initial begin
    int n;
    int zeros;
    for (int i = 0; i < 4; i++) tx_data_v[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx_v[0]), 32'd1);
    check_eq("rst_ready", 32'(ready_v[0]), 32'd1);
    check_eq("rst_busy", 32'(busy_v[0]), 32'd0);
    check_eq("rst_tx_8n2", 32'(tx_v[3]), 32'd1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send(0, 8'hA5);
    frame_check(0, "t1_a5", 12'h34A, 10, 8'h00, 1'b0, gap);

    send(1, 8'h07);
    frame_check(1, "t2_even_07", 12'h60E, 11, 8'h00, 1'b0, gap);
    send(2, 8'h07);
    frame_check(2, "t2_odd_07", 12'h40E, 11, 8'h00, 1'b0, gap);

    send(3, 8'h00);
    frame_check(3, "t3_2stop_00", 12'h600, 11, 8'h00, 1'b0, gap);

    // Valid held across three bytes; data changes mid-frame to the next byte.
    @(negedge clk);
    tx_data_v[0]  = 8'h3C;
    tx_valid_v[0] = 1'b1;
    frame_check(0, "t4_3c", 12'h278, 10, 8'h81, 1'b1, gap);
    frame_check(0, "t4_81", 12'h302, 10, 8'hFF, 1'b1, gap);
    check_eq("t4_gap1", 32'(gap), 32'd8);
    frame_check(0, "t4_ff", 12'h3FE, 10, 8'h00, 1'b0, gap);
    check_eq("t4_gap2", 32'(gap), 32'd8);

    send(0, 8'h00);
    tx_valid_v[0] = 1'b0;
    n = 0;
    while (tx_v[0] !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    repeat (5 * 8 + 4) @(negedge clk);
    check_eq("t5_data_bit4", 32'(tx_v[0]), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("t5_async_tx", 32'(tx_v[0]), 32'd1);
    check_eq("t5_async_ready", 32'(ready_v[0]), 32'd1);
    check_eq("t5_async_busy", 32'(busy_v[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    zeros = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) zeros++;
    end
    check_eq("t5_no_residual", 32'(zeros), 32'd0);
    check_eq("t5_ready_after", 32'(ready_v[0]), 32'd1);

    @(negedge clk);
    baud_run = 1'b0;
    send(0, 8'h5A);
    tx_valid_v[0] = 1'b0;
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) zeros++;
    end
    check_eq("t6_stall_tx", 32'(zeros), 32'd0);
    check_eq("t6_stall_busy", 32'(busy_v[0]), 32'd1);
    check_eq("t6_stall_ready", 32'(ready_v[0]), 32'd0);
    baud_run = 1'b1;
    frame_check(0, "t6_5a", 12'h2B4, 10, 8'h00, 1'b0, gap);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
